alu181_seq: RTL

Nibble-serial sequencer that drives one external sn74181 ALU slice to perform WIDTH-bit operations over WIDTH/4 clock cycles, least significant nibble first.
- Latches operands and function code on a start handshake.
- Presents one nibble pair per cycle to the ALU and chains the ALU carry through a flip-flop between cycles.
- Assembles the result, final carry and A=B status, then signals done.
- Sits between microcode/control logic and the 74181 slice in slice-serial datapaths.

---
 rtl/alu181_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/alu181_seq.sv
// alu181_seq: nibble-serial sequencer for a single external sn74181 ALU slice.
// Runs one WIDTH-bit operation over WIDTH/4 cycles, least significant nibble first.
// The ALU carry is chained between cycles through a flip-flop. The A=B outputs of
// all nibbles are ANDed together.
// Optional build macro ALU181_SEQ_ZERO_EN: when defined, zero is registered as
// "result == 0" at the end of each operation. When undefined, zero is tied to 0.
module alu181_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cin_,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             cout_,
    output logic             aeqb,
    output logic             zero,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_s,
    output logic             alu_m,
    output logic             alu_cn_,
    input  logic [3:0]       alu_f,
    input  logic             alu_cn4_,
    input  logic             alu_aeqb
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);

    // Internal state. alu_cn_ doubles as the inter-nibble carry flop.
    // alu_s and alu_m hold the latched function code.
    logic [1:0]       state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_r;
    logic             aeq_r;
    logic [WIDTH-1:0] res_next_s;

    // Merge the ALU's current nibble into the partial result.
    always_comb begin
        res_next_s = res_r;
        res_next_s[{cnt_r, 2'b00} +: 4] = alu_f;
    end

`ifndef ALU181_SEQ_ZERO_EN
    assign zero = 1'b0;
`endif

    // Sequencer FSM, operand nibble feed, carry chain and result/status registers.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            res_r   <= '0;
            aeq_r   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            f       <= '0;
            cout_   <= 1'b1;
            aeqb    <= 1'b0;
`ifdef ALU181_SEQ_ZERO_EN
            zero    <= 1'b0;
`endif
            alu_a   <= 4'h0;
            alu_b   <= 4'h0;
            alu_s   <= 4'h0;
            alu_m   <= 1'b0;
            alu_cn_ <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        // Nibble 0 goes straight to the ALU. The rest wait in the shifters.
                        alu_a   <= a[3:0];
                        alu_b   <= b[3:0];
                        a_sh_r  <= a >> 3'd4;
                        b_sh_r  <= b >> 3'd4;
                        alu_s   <= s;
                        alu_m   <= m;
                        alu_cn_ <= cin_;
                        cnt_r   <= '0;
                        res_r   <= '0;
                        aeq_r   <= 1'b1;
                        busy    <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    res_r   <= res_next_s;
                    alu_cn_ <= alu_cn4_;
                    aeq_r   <= aeq_r & alu_aeqb;
                    cnt_r   <= cnt_r + CW'(1'b1);
                    alu_a   <= a_sh_r[3:0];
                    alu_b   <= b_sh_r[3:0];
                    a_sh_r  <= a_sh_r >> 3'd4;
                    b_sh_r  <= b_sh_r >> 3'd4;
                    if (cnt_r == CNT_LAST) begin
                        // Last nibble: publish the result together with the done pulse.
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        f       <= res_next_s;
                        cout_   <= alu_m ? 1'b1 : alu_cn4_;
                        aeqb    <= aeq_r & alu_aeqb;
`ifdef ALU181_SEQ_ZERO_EN
                        zero    <= ~|res_next_s;
`endif
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
